im_fetch: RTL and testbench
===========================

# im_fetch

Instruction-fetch initiator that drives the instruction memory's read port (IM_read, IM_addr, IM_out) and delivers fetched words to decode. It holds the fetch PC, issues one word read per cycle while buffer space exists, queues returned instructions with their PCs in a small prefetch FIFO, and presents them to decode through a valid/ready handshake. A redirect from execute flushes the queue and restarts fetch at a new PC. The instruction memory returns read data combinationally in the same cycle as the address.

## Interface
- ADDR_W, 10, IM word-address width; IM_addr = PC[ADDR_W+1:2]
- DEPTH, 2, prefetch queue entries; power of two, ≥2
- RESET_PC, 32'h0000_0000, fetch PC after reset; low 2 bits ignored
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- IM_read  out  1  read strobe to instruction memory
- IM_addr  out  ADDR_W  word address to instruction memory
- IM_out  in  32  instruction word from memory, valid same cycle as IM_addr
- redirect_valid  in  1  flush and restart fetch
- redirect_pc  in  32  new fetch byte address; bits [1:0] dropped
- inst_valid  out  1  head of queue valid
- inst_ready  in  1  decode accepts head this cycle
- inst_out  out  32  head instruction word
- inst_pc  out  32  byte PC of inst_out

## Operation
- State: fpc (32b, word aligned), queue of DEPTH entries {word, pc}, rd_ptr/wr_ptr (log2 DEPTH bits each), count (log2 DEPTH + 1 bits).
- pop = inst_valid & inst_ready & ~redirect_valid.
- fetch = ~rst & ~redirect_valid & (count < DEPTH | pop).
- IM_read = fetch (combinational); IM_addr = fpc[ADDR_W+1:2] always driven.
- On fetch: push {IM_out, fpc} at wr_ptr; fpc <= fpc + 4 (wraps mod 2^32; IM_addr therefore wraps mod 2^ADDR_W).
- Count update: count + fetch − pop. Push and pop in the same cycle at full are legal; count stays DEPTH.
- Redirect (highest priority after rst): count <= 0, rd_ptr <= wr_ptr <= 0, fpc <= {redirect_pc[31:2], 2'b00}; no push, no pop; inst_valid forced 0 that cycle.
- inst_valid = (count != 0) & ~redirect_valid; inst_out/inst_pc = entry at rd_ptr (registered storage, stable while not popped).
- Held-instruction rule: while inst_valid & ~inst_ready, inst_out and inst_pc do not change.
- No decode-side stall input beyond inst_ready; backpressure propagates by queue full → IM_read low.

## Timing
- Reset (rst high at a clock edge): fpc = RESET_PC & ~3, count = 0, pointers = 0, queue contents = 0. During rst: IM_read = 0, inst_valid = 0, inst_out = 0, inst_pc = 0.
- Reset mid-operation discards all queued entries and in-flight fetch that cycle.
- First IM_read = 1 in the first cycle with rst low, IM_addr = RESET_PC[ADDR_W+1:2].
- Fetch-to-valid latency: 1 cycle (word read in cycle N appears at inst_out in N+1).
- Throughput: one instruction per cycle with inst_ready held high; no bubbles.
- Redirect asserted in cycle N: first fetch from new PC in N+1, its word valid at decode in N+2 (2-cycle redirect penalty).
- Full queue with inst_ready low: IM_read = 0, fpc frozen; when inst_ready rises, fetch resumes the same cycle (pop frees the slot).

## Test plan
- Reset then stream: RESET_PC=0, IM holds word i = 32'hA000_0000+i, inst_ready=1 -> IM_read high from cycle 1, inst_valid from cycle 2, inst_pc = 0,4,8,… with inst_out = A000_0000, A000_0001, … one per cycle, no gaps.
- Backpressure: inst_ready=0 after first instruction -> queue fills to DEPTH=2, IM_read drops, inst_out holds pc 0 word; release inst_ready -> words for pc 0,4,8 delivered in order, none lost or duplicated.
- Redirect mid-stream: redirect_valid with redirect_pc=32'h0000_0103 in cycle 5 -> inst_valid=0 that cycle, queued entries discarded, IM_addr=0x40 next cycle, next delivered inst_pc=0x100.
- Redirect while full and inst_ready=1 -> no pop occurs, queue empties, fetch restarts at new PC; redirect wins over pop.
- Address wrap: ADDR_W=4, start pc 0x3C -> IM_addr 15 then 0; inst_pc 0x3C then 0x40 (fpc keeps counting).
- Reset mid-operation with full queue -> next cycle inst_valid=0, outputs 0, IM_read=0; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/im_fetch.sv
// Instruction-fetch front end: drives the IM read port, buffers returned words with their
// PCs in a small prefetch queue and hands them to decode over a valid/ready handshake.
module im_fetch #(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    output logic              IM_read,
    output logic [ADDR_W-1:0] IM_addr,
    input  logic [31:0]       IM_out,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst_out,
    output logic [31:0]       inst_pc
);

    localparam int unsigned     PtrW     = $clog2(DEPTH);
    localparam int unsigned     CntW     = PtrW + 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);
    localparam logic [31:0]     ResetFpc = {RESET_PC[31:2], 2'b00};

    logic [31:0]     fpc_q, fpc_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [31:0]     word_q [DEPTH];
    logic [31:0]     pc_q   [DEPTH];

    logic head_valid;
    logic pop;
    logic fetch;

    // A pop frees a slot in the same cycle, so a full queue can still fetch.
    always_comb begin
        head_valid = (count_q != '0);
        pop        = head_valid & inst_ready & ~redirect_valid;
        fetch      = ~rst & ~redirect_valid & ((count_q < DepthCnt) | pop);
    end

    always_comb begin
        fpc_d    = fpc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (redirect_valid) begin
            fpc_d    = {redirect_pc[31:2], 2'b00};
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (fetch) begin
                fpc_d    = fpc_q + 32'd4;
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            count_d = count_q + CntW'(fetch) - CntW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fpc_q    <= ResetFpc;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                word_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else begin
            fpc_q    <= fpc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (fetch) begin
                word_q[wr_ptr_q] <= IM_out;
                pc_q[wr_ptr_q]   <= fpc_q;
            end
        end
    end

    assign IM_read    = fetch;
    assign IM_addr    = fpc_q[ADDR_W+1:2];
    // Outputs are forced quiet while rst is held, even before the reset edge lands.
    assign inst_valid = head_valid & ~redirect_valid & ~rst;
    assign inst_out   = rst ? 32'h0 : word_q[rd_ptr_q];
    assign inst_pc    = rst ? 32'h0 : pc_q[rd_ptr_q];

endmodule

// File: tb/tb_im_fetch.sv
// Bench for im_fetch: directed scenarios with fixed expectations, then random traffic
// checked against a queue-based reference model.
module tb_im_fetch;

    localparam int unsigned AW     = 10;
    localparam int unsigned DP     = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic          im_read;
    logic [AW-1:0] im_addr;
    logic [31:0]   im_out;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          inst_valid;
    logic          inst_ready;
    logic [31:0]   inst_out;
    logic [31:0]   inst_pc;

    logic          rst2;
    logic          im_read2;
    logic [3:0]    im_addr2;
    logic [31:0]   im_out2;
    logic          inst_valid2;
    logic [31:0]   inst_out2;
    logic [31:0]   inst_pc2;

    logic [31:0] imem [1 << AW];
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign im_out  = imem[im_addr];
    assign im_out2 = 32'hB000_0000 + {28'h0, im_addr2};

    im_fetch #(.ADDR_W(AW), .DEPTH(DP), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst), .IM_read(im_read), .IM_addr(im_addr), .IM_out(im_out),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_out(inst_out), .inst_pc(inst_pc)
    );

    im_fetch #(.ADDR_W(4), .DEPTH(2), .RESET_PC(32'h0000_003F)) dut_wrap (
        .clk(clk), .rst(rst2), .IM_read(im_read2), .IM_addr(im_addr2), .IM_out(im_out2),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .inst_valid(inst_valid2), .inst_ready(1'b1),
        .inst_out(inst_out2), .inst_pc(inst_pc2)
    );

    // Reference model: a plain FIFO of {pc, word} plus the next fetch address.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } ent_t;

    ent_t        mq [$];
    logic [31:0] m_fpc;

    always @(posedge clk) begin
        bit pp;
        bit ff;
        if (rst) begin
            mq.delete();
            m_fpc = RST_PC & ~32'h3;
        end else if (redirect_valid) begin
            mq.delete();
            m_fpc = redirect_pc & ~32'h3;
        end else begin
            pp = (mq.size() > 0) && inst_ready;
            ff = (mq.size() < DP) || pp;
            if (pp) void'(mq.pop_front());
            if (ff) begin
                mq.push_back('{pc: m_fpc, word: imem[m_fpc[AW+1:2]]});
                m_fpc = m_fpc + 32'd4;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; inst_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
        tick();
        tick();
        @(negedge clk);
        n_vec++;
        if (im_read !== 1'b0) begin
            n_err++; $display("FAIL reset_im_read got %0b want 0", im_read);
        end
        n_vec++;
        if (inst_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_valid got %0b want 0", inst_valid);
        end
        n_vec++;
        if (inst_out !== 32'h0 || inst_pc !== 32'h0) begin
            n_err++; $display("FAIL reset_outputs got %h/%h want 0/0", inst_out, inst_pc);
        end
    endtask

    task automatic test_stream();
        do_reset();
        inst_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if (im_read !== 1'b1 || im_addr !== 10'd0 || inst_valid !== 1'b0) begin
            n_err++;
            $display("FAIL stream_first got rd=%0b addr=%0d v=%0b want 1/0/0",
                     im_read, im_addr, inst_valid);
        end
        for (int k = 0; k < 10; k++) begin
            tick();
            @(negedge clk);
            n_vec++;
            if (inst_valid !== 1'b1 || inst_pc !== 32'(4 * k) ||
                inst_out !== 32'hA000_0000 + 32'(k)) begin
                n_err++;
                $display("FAIL stream_%0d got v=%0b pc=%h out=%h want 1/%h/%h", k,
                         inst_valid, inst_pc, inst_out, 4 * k, 32'hA000_0000 + 32'(k));
            end
            n_vec++;
            if (im_read !== 1'b1 || im_addr !== AW'(k + 1)) begin
                n_err++;
                $display("FAIL stream_fetch_%0d got rd=%0b addr=%0d want 1/%0d", k,
                         im_read, im_addr, k + 1);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        inst_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            @(negedge clk);
            n_vec++;
            if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst_out !== 32'hA000_0000) begin
                n_err++;
                $display("FAIL bp_hold_%0d got v=%0b pc=%h out=%h want 1/0/a0000000", c,
                         inst_valid, inst_pc, inst_out);
            end
            n_vec++;
            if (im_read !== (c == 0)) begin
                n_err++; $display("FAIL bp_read_%0d got %0b want %0b", c, im_read, c == 0);
            end
        end
        tick();
        inst_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if (im_read !== 1'b1 || im_addr !== 10'd2) begin
            n_err++;
            $display("FAIL bp_resume got rd=%0b addr=%0d want 1/2", im_read, im_addr);
        end
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                tick();
                @(negedge clk);
            end
            n_vec++;
            if (inst_valid !== 1'b1 || inst_pc !== 32'(4 * k) ||
                inst_out !== 32'hA000_0000 + 32'(k)) begin
                n_err++;
                $display("FAIL bp_drain_%0d got v=%0b pc=%h out=%h want 1/%h", k,
                         inst_valid, inst_pc, inst_out, 4 * k);
            end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        inst_ready = 1'b1;
        for (int c = 0; c < 4; c++) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        @(negedge clk);
        n_vec++;
        if (inst_valid !== 1'b0 || im_read !== 1'b0) begin
            n_err++;
            $display("FAIL redir_cycle got v=%0b rd=%0b want 0/0", inst_valid, im_read);
        end
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if (im_addr !== 10'h40 || im_read !== 1'b1 || inst_valid !== 1'b0) begin
            n_err++;
            $display("FAIL redir_fetch got addr=%h rd=%0b v=%0b want 40/1/0",
                     im_addr, im_read, inst_valid);
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            @(negedge clk);
            n_vec++;
            if (inst_valid !== 1'b1 || inst_pc !== 32'h100 + 32'(4 * k) ||
                inst_out !== 32'hA000_0040 + 32'(k)) begin
                n_err++;
                $display("FAIL redir_deliver_%0d got v=%0b pc=%h out=%h want 1/%h", k,
                         inst_valid, inst_pc, inst_out, 32'h100 + 32'(4 * k));
            end
        end
    endtask

    task automatic test_redirect_full();
        do_reset();
        inst_ready = 1'b0;
        tick();
        tick();
        @(negedge clk);
        n_vec++;
        if (im_read !== 1'b0 || inst_valid !== 1'b1) begin
            n_err++;
            $display("FAIL rf_full got rd=%0b v=%0b want 0/1", im_read, inst_valid);
        end
        tick();
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        @(negedge clk);
        n_vec++;
        if (inst_valid !== 1'b0 || im_read !== 1'b0) begin
            n_err++;
            $display("FAIL rf_redir got v=%0b rd=%0b want 0/0", inst_valid, im_read);
        end
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if (inst_valid !== 1'b0 || im_addr !== 10'h80 || im_read !== 1'b1) begin
            n_err++;
            $display("FAIL rf_restart got v=%0b addr=%h rd=%0b want 0/80/1",
                     inst_valid, im_addr, im_read);
        end
        tick();
        @(negedge clk);
        n_vec++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h200 || inst_out !== 32'hA000_0080) begin
            n_err++;
            $display("FAIL rf_deliver got v=%0b pc=%h out=%h want 1/200/a0000080",
                     inst_valid, inst_pc, inst_out);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        inst_ready = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_vec++;
            if (inst_valid !== 1'b0 || im_read !== 1'b0 || inst_out !== 32'h0 ||
                inst_pc !== 32'h0) begin
                n_err++;
                $display("FAIL rmid_hold_%0d got v=%0b rd=%0b out=%h pc=%h want 0/0/0/0", c,
                         inst_valid, im_read, inst_out, inst_pc);
            end
            tick();
        end
        rst        = 1'b0;
        inst_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if (inst_valid !== 1'b0 || inst_out !== 32'h0 || im_read !== 1'b1 ||
            im_addr !== 10'd0) begin
            n_err++;
            $display("FAIL rmid_release got v=%0b out=%h rd=%0b addr=%0d want 0/0/1/0",
                     inst_valid, inst_out, im_read, im_addr);
        end
        tick();
        @(negedge clk);
        n_vec++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst_out !== 32'hA000_0000) begin
            n_err++;
            $display("FAIL rmid_first got v=%0b pc=%h out=%h want 1/0/a0000000",
                     inst_valid, inst_pc, inst_out);
        end
    endtask

    task automatic test_wrap();
        tick();
        rst2 = 1'b0;
        @(negedge clk);
        n_vec++;
        if (im_read2 !== 1'b1 || im_addr2 !== 4'd15) begin
            n_err++; $display("FAIL wrap_first got rd=%0b addr=%0d want 1/15", im_read2, im_addr2);
        end
        tick();
        @(negedge clk);
        n_vec++;
        if (im_addr2 !== 4'd0 || inst_valid2 !== 1'b1 || inst_pc2 !== 32'h3C ||
            inst_out2 !== 32'hB000_000F) begin
            n_err++;
            $display("FAIL wrap_edge got addr=%0d v=%0b pc=%h out=%h want 0/1/3c/b000000f",
                     im_addr2, inst_valid2, inst_pc2, inst_out2);
        end
        tick();
        @(negedge clk);
        n_vec++;
        if (im_addr2 !== 4'd1 || inst_pc2 !== 32'h40 || inst_out2 !== 32'hB000_0000) begin
            n_err++;
            $display("FAIL wrap_after got addr=%0d pc=%h out=%h want 1/40/b0000000",
                     im_addr2, inst_pc2, inst_out2);
        end
    endtask

    task automatic test_random();
        int          sz;
        logic        e_rd;
        logic        e_vl;
        logic [AW-1:0] e_ad;
        for (int i = 0; i < (1 << AW); i++) imem[i] = $urandom;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c > 0) begin
                tick();
                rst            = ($urandom_range(0, 199) == 0);
                redirect_valid = ($urandom_range(0, 15) == 0);
                redirect_pc    = $urandom;
                inst_ready     = ($urandom_range(0, 2) != 0);
            end
            @(negedge clk);
            sz   = mq.size();
            e_rd = !rst && !redirect_valid && (sz < DP || (sz > 0 && inst_ready));
            e_vl = !rst && !redirect_valid && (sz > 0);
            e_ad = m_fpc[AW+1:2];
            n_vec++;
            if (im_read !== e_rd || im_addr !== e_ad || inst_valid !== e_vl) begin
                n_err++;
                $display("FAIL rand_ctl_%0d got rd=%0b addr=%h v=%0b want %0b/%h/%0b", c,
                         im_read, im_addr, inst_valid, e_rd, e_ad, e_vl);
            end
            if (e_vl) begin
                n_vec++;
                if (inst_pc !== mq[0].pc || inst_out !== mq[0].word) begin
                    n_err++;
                    $display("FAIL rand_head_%0d got pc=%h out=%h want %h/%h", c,
                             inst_pc, inst_out, mq[0].pc, mq[0].word);
                end
            end
        end
    endtask

    initial begin
        rst            = 1'b1;
        rst2           = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_ready     = 1'b1;
        for (int i = 0; i < (1 << AW); i++) imem[i] = 32'hA000_0000 + 32'(i);
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_redirect_full();
        test_reset_mid();
        test_wrap();
        test_random();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
